// File: rtl/jtopl_pkg.sv
// jtopl_pkg: shared constants and slot decode for the OPL slot sequencer
package jtopl_pkg;
  localparam int SLOTS = 18;
  localparam int RHY_FIRST_SLOT = 12;
  localparam int NUM_CH = 9;
  // slots run in groups of six: three modulators then the matching three carriers
  function automatic logic [4:0] slot2ch(input logic [4:0] idx);
    logic [4:0] grp, sub;
    grp = idx / 5'd6;
    sub = idx % 5'd6;
    return {4'(grp * 5'd3 + sub % 5'd3), sub >= 5'd3};
  endfunction
endpackage

// File: rtl/jtopl_cen_div.sv
// jtopl_cen_div: divides clk down to a one-cycle operator enable
module jtopl_cen_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic cenop
);
  localparam int CW = $clog2(DIV);
  logic [CW-1:0] cnt;
  logic last;
  assign last = cnt == CW'(DIV - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      cenop <= 1'b0;
    end else begin
      cnt <= last ? '0 : cnt + 1'b1;
      cenop <= last;
    end
  end
endmodule

// File: rtl/jtopl_slot_seq.sv
// jtopl_slot_seq: rotates the one-hot operator slot, decodes channel/op,
// steps the vibrato counter and opens per-channel register write windows
module jtopl_slot_seq #(
  parameter int DIV = 4,
  parameter int SLOTS = 18,
  parameter int VIB_FRAMES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rhy_en,
  input  logic        upd_req,
  input  logic [3:0]  upd_ch,
  output logic        cenop,
  output logic [17:0] slot,
  output logic [4:0]  slot_idx,
  output logic [3:0]  ch,
  output logic        op,
  output logic        zero,
  output logic        rhy_slot,
  output logic [2:0]  vib_cnt,
  output logic        upd_ack,
  output logic        upd_err
);
  import jtopl_pkg::*;
  localparam int FW = VIB_FRAMES > 1 ? $clog2(VIB_FRAMES) : 1;
  logic [FW-1:0] frame_cnt;
  logic [4:0] target;
  logic last_slot, last_frame, bad, bad_q;
  logic [3:0] bad_ch;
  jtopl_cen_div #(.DIV(DIV)) u_div (.clk(clk), .rst(rst), .cenop(cenop));
  always_comb begin
    {ch, op} = slot2ch(slot_idx);
    zero = slot_idx == 5'd0;
    rhy_slot = rhy_en & (slot_idx >= 5'(RHY_FIRST_SLOT));
    last_slot = slot_idx == 5'(SLOTS - 1);
    last_frame = frame_cnt == FW'(VIB_FRAMES - 1);
    target = 5'(upd_ch / 4'd3) * 5'd6 + 5'(upd_ch % 4'd3);
    bad = upd_req & (upd_ch >= 4'(NUM_CH));
    upd_ack = upd_req & cenop & ~(upd_ch >= 4'(NUM_CH)) & (slot_idx == target);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= 18'd1;
      slot_idx <= 5'd0;
      frame_cnt <= '0;
      vib_cnt <= 3'd0;
      upd_err <= 1'b0;
      bad_q <= 1'b0;
      bad_ch <= 4'd0;
    end else begin
      if (cenop) begin
        slot <= {slot[16:0], slot[17]};
        slot_idx <= last_slot ? 5'd0 : slot_idx + 5'd1;
        if (last_slot) begin
          frame_cnt <= last_frame ? '0 : frame_cnt + 1'b1;
          if (last_frame) vib_cnt <= vib_cnt + 3'd1;
        end
      end
      // a held bad request reports once, again only if it drops or retargets
      upd_err <= bad & (~bad_q | (upd_ch != bad_ch));
      bad_q <= bad;
      bad_ch <= upd_ch;
    end
  end
endmodule

// File: tb/tb_jtopl_slot_seq.sv
// tb_jtopl_slot_seq: closed-form timing model plus directed corner sequences
module tb_jtopl_slot_seq;
  localparam int DIV = 4;
  localparam int VF = 4;
  logic clk = 0, rst = 1, rhy_en = 0, upd_req = 0;
  logic [3:0] upd_ch = 0;
  logic cenop, op, zero, rhy_slot, upd_ack, upd_err;
  logic [17:0] slot;
  logic [4:0] slot_idx;
  logic [3:0] ch;
  logic [2:0] vib_cnt;
  int k = 0, comp = 0, fails = 0;
  logic pbad = 0;
  logic [3:0] pch = 0;

  jtopl_slot_seq #(.DIV(DIV), .VIB_FRAMES(VF)) dut (
    .clk(clk), .rst(rst), .rhy_en(rhy_en), .upd_req(upd_req), .upd_ch(upd_ch),
    .cenop(cenop), .slot(slot), .slot_idx(slot_idx), .ch(ch), .op(op), .zero(zero),
    .rhy_slot(rhy_slot), .vib_cnt(vib_cnt), .upd_ack(upd_ack), .upd_err(upd_err)
  );

  always #5 clk = ~clk;

  function automatic void cmp(string name, int act, int exp);
    comp++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at k=%0d: got %0d expected %0d", name, k, act, exp);
    end
  endfunction

  // k = clk edges since reset released; every output follows from k and the inputs
  task automatic tick();
    int n, idx, grp, sub, tgt;
    logic e_cen, e_ack, e_err, b;
    @(posedge clk);
    #1;
    b = upd_req && upd_ch > 8;
    if (rst) begin
      k = 0;
      e_err = 0;
      pbad = 0;
    end else begin
      k++;
      e_err = b && (!pbad || upd_ch != pch);
      pbad = b;
    end
    pch = upd_ch;
    n = k == 0 ? 0 : (k - 1) / DIV;
    idx = n % 18;
    grp = idx / 6;
    sub = idx % 6;
    tgt = 6 * (upd_ch / 3) + upd_ch % 3;
    e_cen = k > 0 && k % DIV == 0;
    e_ack = upd_req && e_cen && upd_ch <= 8 && idx == tgt;
    cmp("cenop", cenop, e_cen);
    cmp("slot", slot, 1 << idx);
    cmp("slot_idx", slot_idx, idx);
    cmp("ch", ch, 3 * grp + sub % 3);
    cmp("op", op, sub >= 3);
    cmp("zero", zero, idx == 0);
    cmp("rhy_slot", rhy_slot, rhy_en && idx >= 12);
    cmp("vib_cnt", vib_cnt, (n / 18 / VF) % 8);
    cmp("upd_ack", upd_ack, e_ack);
    cmp("upd_err", upd_err, e_err);
    if (k == 4) cmp("first_cenop", cenop, 1);
    if (k == 5) cmp("slot_after_first", slot, 2);
    if (k == 73) cmp("frame_wrap_slot", slot, 1);
    if (k == 288) cmp("vib_before_step", vib_cnt, 0);
    if (k == 289) cmp("vib_step", vib_cnt, 1);
    if (k == 2304) cmp("vib_at_7", vib_cnt, 7);
    if (k == 2305) cmp("vib_wrap", vib_cnt, 0);
  endtask

  task automatic wait_idx(input int t);
    for (int i = 0; i < 100 && slot_idx != 5'(t); i++) tick();
    cmp("wait_idx", slot_idx, t);
  endtask

  typedef struct {
    int idx;
    int ch;
    int op;
    int rhy;
  } dvec_t;
  dvec_t tbl[6];

  initial begin
    int acks, errs, cnt;
    tbl[0] = '{0, 0, 0, 0};
    tbl[1] = '{4, 1, 1, 0};
    tbl[2] = '{10, 4, 1, 0};
    tbl[3] = '{12, 6, 0, 1};
    tbl[4] = '{13, 7, 0, 1};
    tbl[5] = '{17, 8, 1, 1};
    repeat (3) tick();
    rst = 0;
    // long reset-free run: divider, ring, vibrato step and wrap
    for (int i = 0; i < 2310; i++) begin
      rhy_en = 1'($urandom);
      tick();
    end
    // decode table
    rhy_en = 1;
    for (int i = 0; i < 6; i++) begin
      wait_idx(tbl[i].idx);
      cmp("tbl_ch", ch, tbl[i].ch);
      cmp("tbl_op", op, tbl[i].op);
      cmp("tbl_rhy", rhy_slot, tbl[i].rhy);
      rhy_en = 0;
      #1;
      cmp("rhy_off_same_cycle", rhy_slot, 0);
      rhy_en = 1;
      #1;
    end
    rhy_en = 0;
    // ack window for channel 7
    wait_idx(2);
    upd_req = 1;
    upd_ch = 7;
    acks = 0;
    for (int i = 0; i < 160; i++) begin
      tick();
      if (upd_ack) begin
        acks++;
        cmp("ack7_idx", slot_idx, 13);
        cmp("ack7_cen", cenop, 1);
        upd_req = 0;
      end
    end
    cmp("ack7_count", acks, 1);
    upd_ch = 0;
    upd_req = 1;
    cnt = 0;
    while (!upd_ack && cnt < 100) begin
      tick();
      cnt++;
    end
    cmp("ack0_seen", upd_ack, 1);
    cmp("ack0_idx", slot_idx, 0);
    upd_req = 0;
    // invalid channel held three frames
    upd_ch = 9;
    upd_req = 1;
    acks = 0;
    errs = 0;
    for (int i = 0; i < 3 * 18 * DIV; i++) begin
      tick();
      acks += int'(upd_ack);
      errs += int'(upd_err);
    end
    cmp("err_count", errs, 1);
    cmp("err_acks", acks, 0);
    upd_req = 0;
    // reset mid-frame
    wait_idx(9);
    rst = 1;
    tick();
    rst = 0;
    cmp("rst_slot", slot, 1);
    cmp("rst_vib", vib_cnt, 0);
    cmp("rst_cen", cenop, 0);
    cnt = 0;
    while (!cenop && cnt < 20) begin
      tick();
      cnt++;
    end
    cmp("rst_first_cenop", cnt, DIV);
    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rhy_en = 1'($urandom);
      if ($urandom_range(0, 15) == 0) upd_req = 1'($urandom);
      if ($urandom_range(0, 31) == 0) upd_ch = 4'($urandom_range(0, 15));
      rst = $urandom_range(0, 499) == 0;
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comp, fails);
    $finish;
  end
endmodule
